// File: rtl/wbc_rst_pkg.sv
// Shared types and widths for the QK7 reset/timebase controller.
package wbc_rst_pkg;

  localparam int unsigned US_PER_MS = 1000;

  localparam int unsigned US_W  = 8;
  localparam int unsigned MS_W  = 10;
  localparam int unsigned DLY_W = 16;
  localparam int unsigned DEB_W = 8;

  typedef enum logic [2:0] {
    ST_PWR  = 3'd0,
    ST_SYS  = 3'd1,
    ST_RUN  = 3'd2,
    ST_HOLD = 3'd3,
    ST_SOFT = 3'd4
  } rst_state_e;

endpackage

// File: rtl/wbc_rst_deb.sv
// Reset-button synchronizer with optional ms-rate debouncer.
// Debouncer is present only when WBC_RST_DEBOUNCE_EN is defined.
module wbc_rst_deb
  import wbc_rst_pkg::*;
#(
  parameter int unsigned DEB_MS = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic ena_ms,
  input  logic in_n,
  output logic out
);

  logic [1:0] sync_q, sync_d;

  // Two-stage synchronizer shift, newest sample in bit 0
  always_comb begin
    sync_d = {sync_q[0], in_n};
  end

  // Synchronizer flops; reset to the released (high) level
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= sync_d;
    end
  end

`ifdef WBC_RST_DEBOUNCE_EN
  logic             btn_q, btn_d;
  logic [DEB_W-1:0] cnt_q, cnt_d;
  logic             smp;

  // Count consecutive ms samples that disagree with the current output
  always_comb begin
    smp   = ~sync_q[1];
    btn_d = btn_q;
    cnt_d = cnt_q;
    if (ena_ms) begin
      if (smp == btn_q) begin
        cnt_d = '0;
      end else if (cnt_q == DEB_W'(DEB_MS - 1)) begin
        btn_d = smp;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + DEB_W'(1);
      end
    end
  end

  // Debouncer state; starts released
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      btn_q <= btn_d;
      cnt_q <= cnt_d;
    end
  end

  assign out = btn_q;
`else
  logic             unused_ena_ms;
  logic [DEB_W-1:0] unused_deb_ms;

  assign unused_ena_ms = ena_ms;
  assign unused_deb_ms = DEB_W'(DEB_MS);
  assign out           = ~sync_q[1];
`endif

endmodule

// File: rtl/wbc_rst_ctl.sv
// QK7 reset and timebase controller: us/ms strobes plus power, system,
// button-hold and soft reset sequencing. Optional button debouncing is
// enabled by defining WBC_RST_DEBOUNCE_EN.
module wbc_rst_ctl
  import wbc_rst_pkg::*;
#(
  parameter int unsigned CLK_MHZ = 100,
  parameter int unsigned PWR_MS  = 10,
  parameter int unsigned RST_MS  = 2,
  parameter int unsigned SOFT_US = 10,
  parameter int unsigned DEB_MS  = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic ext_reset,
  input  logic soft_req,
  output logic pwr_rst,
  output logic sys_rst,
  output logic ena_us,
  output logic ena_ms
);

  localparam logic [US_W-1:0] US_LAST = US_W'(CLK_MHZ - 1);
  localparam logic [MS_W-1:0] MS_LAST = MS_W'(US_PER_MS - 1);

  logic [US_W-1:0]  us_cnt_q, us_cnt_d;
  logic [MS_W-1:0]  ms_cnt_q, ms_cnt_d;
  logic             ena_us_q, ena_us_d;
  logic             ena_ms_q, ena_ms_d;
  rst_state_e       state_q, state_d;
  logic [DLY_W-1:0] dly_q, dly_d;
  logic             pwr_rst_q, pwr_rst_d;
  logic             sys_rst_q, sys_rst_d;
  logic             btn;
  logic             dly_last;

  wbc_rst_deb #(
    .DEB_MS (DEB_MS)
  ) u_deb (
    .clk    (clk),
    .rst    (rst),
    .ena_ms (ena_ms_q),
    .in_n   (ext_reset),
    .out    (btn)
  );

  // Prescalers; strobes are precomputed from the next counter values
  always_comb begin
    us_cnt_d = (us_cnt_q == US_LAST) ? '0 : us_cnt_q + US_W'(1);
    ms_cnt_d = ms_cnt_q;
    if (ena_us_q) begin
      ms_cnt_d = (ms_cnt_q == MS_LAST) ? '0 : ms_cnt_q + MS_W'(1);
    end
    ena_us_d = (us_cnt_d == US_LAST);
    ena_ms_d = ena_us_d && (ms_cnt_d == MS_LAST);
  end

  assign dly_last = (dly_q == DLY_W'(1));

  // Reset sequencer next state; transition happens on the final strobe
  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    case (state_q)
      ST_PWR: begin
        if (ena_ms_q) begin
          if (dly_last) begin
            state_d = ST_SYS;
            dly_d   = DLY_W'(RST_MS);
          end else begin
            dly_d = dly_q - DLY_W'(1);
          end
        end
      end
      ST_SYS: begin
        if (ena_ms_q) begin
          if (dly_last) begin
            state_d = ST_RUN;
            dly_d   = '0;
          end else begin
            dly_d = dly_q - DLY_W'(1);
          end
        end
      end
      ST_RUN: begin
        if (btn) begin
          state_d = ST_HOLD;
        end else if (soft_req) begin
          state_d = ST_SOFT;
          dly_d   = DLY_W'(SOFT_US);
        end
      end
      ST_HOLD: begin
        if (!btn) begin
          state_d = ST_SYS;
          dly_d   = DLY_W'(RST_MS);
        end
      end
      ST_SOFT: begin
        if (btn) begin
          state_d = ST_HOLD;
        end else if (ena_us_q) begin
          if (dly_last) begin
            state_d = ST_RUN;
            dly_d   = '0;
          end else begin
            dly_d = dly_q - DLY_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_PWR;
        dly_d   = DLY_W'(PWR_MS);
      end
    endcase
    pwr_rst_d = (state_d == ST_PWR);
    sys_rst_d = (state_d != ST_RUN);
  end

  // All state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      us_cnt_q  <= '0;
      ms_cnt_q  <= '0;
      ena_us_q  <= 1'b0;
      ena_ms_q  <= 1'b0;
      state_q   <= ST_PWR;
      dly_q     <= DLY_W'(PWR_MS);
      pwr_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
    end else begin
      us_cnt_q  <= us_cnt_d;
      ms_cnt_q  <= ms_cnt_d;
      ena_us_q  <= ena_us_d;
      ena_ms_q  <= ena_ms_d;
      state_q   <= state_d;
      dly_q     <= dly_d;
      pwr_rst_q <= pwr_rst_d;
      sys_rst_q <= sys_rst_d;
    end
  end

  assign pwr_rst = pwr_rst_q;
  assign sys_rst = sys_rst_q;
  assign ena_us  = ena_us_q;
  assign ena_ms  = ena_ms_q;

endmodule

// File: tb/tb_wbc_rst_ctl.sv
// Self-checking bench for wbc_rst_ctl: deadline-based reference model
// compared every cycle, plus literal timing pins.
module tb_wbc_rst_ctl;

  localparam int unsigned CLK_MHZ = 4;
  localparam int unsigned PWR_MS  = 3;
  localparam int unsigned RST_MS  = 2;
  localparam int unsigned SOFT_US = 5;
  localparam int unsigned DEB_MS  = 2;
  localparam int unsigned CPM     = CLK_MHZ * 1000;

  logic clk       = 1'b0;
  logic rst       = 1'b1;
  logic ext_reset = 1'b1;
  logic soft_req  = 1'b0;
  logic pwr_rst, sys_rst, ena_us, ena_ms;

  wbc_rst_ctl #(
    .CLK_MHZ (CLK_MHZ),
    .PWR_MS  (PWR_MS),
    .RST_MS  (RST_MS),
    .SOFT_US (SOFT_US),
    .DEB_MS  (DEB_MS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ext_reset (ext_reset),
    .soft_req  (soft_req),
    .pwr_rst   (pwr_rst),
    .sys_rst   (sys_rst),
    .ena_us    (ena_us),
    .ena_ms    (ena_ms)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum int {M_PWR, M_SYS, M_RUN, M_HOLD, M_SOFT} mmode_t;

  mmode_t      mode;
  int unsigned t;        // index of current cycle since rst release
  int unsigned end_t;    // cycle whose edge ends the current timed phase
  bit          h0, h1;   // ext_reset sampled two edges ago / last edge
  bit          deb_btn;
  bit          smpq[$];
  bit          model_valid = 1'b0;
  bit          exp_pwr, exp_sys, exp_eus, exp_ems;
  bit          m_raw, m_b, m_em, m_same;

  // Cycle of the k-th strobe (period p, last slot) at or after cycle e
  function automatic int unsigned deadline(input int unsigned e,
                                           input int unsigned p,
                                           input int unsigned k);
    int unsigned first;
    first = e + (((p - 1) + p - (e % p)) % p);
    return first + (k - 1) * p;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      t           = 0;
      mode        = M_PWR;
      end_t       = deadline(0, CPM, PWR_MS);
      h0          = 1'b1;
      h1          = 1'b1;
      deb_btn     = 1'b0;
      smpq.delete();
      model_valid = 1'b1;
    end else begin
      m_raw = ~h0;
`ifdef WBC_RST_DEBOUNCE_EN
      m_b = deb_btn;
`else
      m_b = m_raw;
`endif
      case (mode)
        M_PWR:  if (t == end_t) begin mode = M_SYS; end_t = deadline(t + 1, CPM, RST_MS); end
        M_SYS:  if (t == end_t) mode = M_RUN;
        M_RUN:  if (m_b) mode = M_HOLD;
                else if (soft_req) begin mode = M_SOFT; end_t = deadline(t + 1, CLK_MHZ, SOFT_US); end
        M_HOLD: if (!m_b) begin mode = M_SYS; end_t = deadline(t + 1, CPM, RST_MS); end
        M_SOFT: if (m_b) mode = M_HOLD;
                else if (t == end_t) mode = M_RUN;
        default: mode = M_PWR;
      endcase
      m_em = ((t % CPM) == CPM - 1);
      if (m_em) begin
        smpq.push_back(m_raw);
        if (smpq.size() > DEB_MS) void'(smpq.pop_front());
        if (smpq.size() == DEB_MS) begin
          m_same = 1'b1;
          foreach (smpq[i]) if (smpq[i] != smpq[0]) m_same = 1'b0;
          if (m_same) deb_btn = smpq[0];
        end
      end
      h0 = h1;
      h1 = ext_reset;
      t  = t + 1;
    end
    exp_pwr = (mode == M_PWR);
    exp_sys = (mode != M_RUN);
    exp_eus = ((t % CLK_MHZ) == CLK_MHZ - 1);
    exp_ems = ((t % CPM) == CPM - 1);
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (model_valid) begin
      chk("pwr_rst", int'(pwr_rst), int'(exp_pwr));
      chk("sys_rst", int'(sys_rst), int'(exp_sys));
      chk("ena_us",  int'(ena_us),  int'(exp_eus));
      chk("ena_ms",  int'(ena_ms),  int'(exp_ems));
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_run();
    int n;
    n = 0;
    while (mode != M_RUN && n < 30000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 30000) chk("wait_run_timeout_sys_rst", int'(sys_rst), 0);
  endtask

  // Called at the negedge where rst was just released (cycle 0)
  task automatic powerup_check(input string tag);
    int fu, fm, fp, fs;
    fu = -1; fm = -1; fp = -1; fs = -1;
    for (int i = 1; i <= 20005; i++) begin
      @(negedge clk);
      if (ena_us  && fu < 0) fu = i;
      if (ena_ms  && fm < 0) fm = i;
      if (!pwr_rst && fp < 0) fp = i;
      if (!sys_rst && fs < 0) fs = i;
      soft_req = (i < 19990) && ($urandom_range(0, 499) == 0);
    end
    soft_req = 1'b0;
    chk({tag, "_first_ena_us"}, fu, 3);
    chk({tag, "_first_ena_ms"}, fm, 3999);
    chk({tag, "_pwr_rst_fall"}, fp, 12000);
    chk({tag, "_sys_rst_fall"}, fs, 20000);
  endtask

  initial begin
    int cnt, first_k, press_left, n;

    // reset state
    rst = 1'b1;
    repeat (4) @(negedge clk);
    chk("reset_pwr_rst", int'(pwr_rst), 1);
    chk("reset_sys_rst", int'(sys_rst), 1);
    chk("reset_ena_us",  int'(ena_us),  0);
    chk("reset_ena_ms",  int'(ena_ms),  0);
    rst = 1'b0;
    powerup_check("pwrup1");

    // soft reset aligned right before a us strobe: exactly 5 us high
    wait_run();
    n = 0;
    while ((t % CLK_MHZ) != CLK_MHZ - 1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    soft_req = 1'b1;
    @(negedge clk);
    soft_req = 1'b0;
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      if (sys_rst) cnt++;
      chk("soft_pwr_rst_low", int'(pwr_rst), 0);
      @(negedge clk);
    end
    chk("soft_sys_rst_width", cnt, 20);

    // button pressed for 3 cycles
    wait_run();
    ext_reset = 1'b0;
    first_k = -1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (sys_rst && first_k < 0) first_k = k;
      if (k == 3) ext_reset = 1'b1;
    end
`ifndef WBC_RST_DEBOUNCE_EN
    chk("btn_to_hold_latency", first_k, 3);
`endif

    // button and soft_req reach the sequencer in the same cycle
    wait_run();
    ext_reset = 1'b0;
    repeat (2) @(negedge clk);
    soft_req = 1'b1;
    @(negedge clk);
    soft_req = 1'b0;
    repeat (10) @(negedge clk);
    ext_reset = 1'b1;

    // button while soft reset is running
    wait_run();
    soft_req = 1'b1;
    @(negedge clk);
    soft_req = 1'b0;
    repeat (3) @(negedge clk);
    ext_reset = 1'b0;
    repeat (20) @(negedge clk);
    ext_reset = 1'b1;

    // randomized mix of soft requests, presses and glitches
    wait_run();
    press_left = 0;
    for (int i = 0; i < 8000; i++) begin
      soft_req = ($urandom_range(0, 199) == 0);
      if (press_left > 0) begin
        ext_reset  = 1'b0;
        press_left = press_left - 1;
      end else if ($urandom_range(0, 1999) == 0) begin
        press_left = int'($urandom_range(1, 9000));
        ext_reset  = 1'b0;
      end else begin
        ext_reset = ($urandom_range(0, 499) != 0);
      end
      @(negedge clk);
    end
    soft_req  = 1'b0;
    ext_reset = 1'b1;

    // rst pulsed while running: full sequence repeats
    wait_run();
    repeat ($urandom_range(1, 50)) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rerst_pwr_rst", int'(pwr_rst), 1);
    chk("rerst_sys_rst", int'(sys_rst), 1);
    rst = 1'b0;
    powerup_check("pwrup2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
